// File: rtl/ws2812_pkg.sv
// ws2812_pkg: WS2812 timing constants and line-state encoding shared by rx and tx
package ws2812_pkg;

  typedef enum logic [1:0] {WAIT_RST, IDLE_LOW, HIGH, LOW} ws2812_state_t;

  function automatic int cnt_min(input int clk_freq);
    return clk_freq / 10_000_000;
  endfunction

  function automatic int cnt_thr(input int clk_freq);
    return clk_freq / 1_600_000;
  endfunction

  function automatic int cnt_max(input int clk_freq);
    return clk_freq / 500_000;
  endfunction

  function automatic int cnt_rst(input int clk_freq);
    return clk_freq / 20_000;
  endfunction

endpackage

// File: rtl/ws2812_sync.sv
// ws2812_sync: 2-flop synchronizer for the WS2812 line plus rise/fall detect
//   sys_clk, rst_n : clock, async active-low reset
//   d              : asynchronous serial input
//   level          : synchronized line level
//   rise, fall     : single-cycle edge flags of the synchronized level
module ws2812_sync (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else s <= {s[1:0], d};
  // s[0], s[1] form the synchronizer; s[2] is only the previous synchronized level
  assign level = s[1];
  assign rise  = s[1] & ~s[2];
  assign fall  = ~s[1] & s[2];
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 serial-line decoder producing GRB pixels and frame/error strobes
//   sys_clk, rst_n              : clock, async active-low reset
//   Di                          : WS2812 data line (asynchronous)
//   pixel_addr, pixel_Red/Green/Blue : decoded pixel, held between strobes
//   pixel_valid                 : one-cycle strobe for the pixel outputs
//   frame_done                  : one-cycle strobe on the line reset ending a frame
//   err                         : one-cycle strobe on a protocol error
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int clk_freq = 50_000_000,
  parameter int used_led = 1
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       Di,
  output logic [7:0] pixel_addr,
  output logic [7:0] pixel_Red,
  output logic [7:0] pixel_Green,
  output logic [7:0] pixel_Blue,
  output logic       pixel_valid,
  output logic       frame_done,
  output logic       err
);
  localparam logic [15:0] CNT_MIN = 16'(cnt_min(clk_freq));
  localparam logic [15:0] CNT_THR = 16'(cnt_thr(clk_freq));
  localparam logic [15:0] CNT_MAX = 16'(cnt_max(clk_freq));
  localparam logic [15:0] CNT_RST = 16'(cnt_rst(clk_freq));

  logic level, rise, fall;
  ws2812_state_t state, prev;
  logic [15:0] hcnt, lcnt;
  logic [23:0] sr, sr_next;
  logic [4:0]  bcnt;
  logic [7:0]  pidx, pend_addr;
  logic        pend;

  ws2812_sync u_sync (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .d      (Di),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign sr_next = {sr[22:0], hcnt >= CNT_THR};

  // hcnt is loaded with 1 on the rise so that it equals the high width in cycles
  // when the fall is seen; lcnt likewise starts at 1 after a bit.
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state       <= WAIT_RST;
      prev        <= WAIT_RST;
      hcnt        <= '0;
      lcnt        <= '0;
      sr          <= '0;
      bcnt        <= '0;
      pidx        <= '0;
      pend        <= 1'b0;
      pend_addr   <= '0;
      pixel_addr  <= '0;
      pixel_Red   <= '0;
      pixel_Green <= '0;
      pixel_Blue  <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      pixel_valid <= pend;
      pend        <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      if (pend) begin
        pixel_addr  <= pend_addr;
        pixel_Green <= sr[23:16];
        pixel_Red   <= sr[15:8];
        pixel_Blue  <= sr[7:0];
      end
      case (state)
        WAIT_RST:
          if (level) lcnt <= '0;
          else if (lcnt >= CNT_RST - 16'd1) begin
            state <= IDLE_LOW;
            lcnt  <= '0;
          end else lcnt <= lcnt + 16'd1;
        IDLE_LOW, LOW:
          if (rise) begin
            prev  <= state;
            state <= HIGH;
            hcnt  <= 16'd1;
          end else if (state == LOW) begin
            if (lcnt >= CNT_RST) begin
              frame_done <= 1'b1;
              err        <= bcnt != 5'd0;
              bcnt       <= '0;
              pidx       <= '0;
              state      <= IDLE_LOW;
            end else lcnt <= lcnt + 16'(lcnt != 16'hFFFF);
          end
        HIGH:
          if (fall) begin
            // a too-short pulse is a glitch: resume the interrupted low period
            if (hcnt < CNT_MIN) state <= prev;
            else begin
              sr    <= sr_next;
              state <= LOW;
              lcnt  <= 16'd1;
              if (bcnt == 5'd23) begin
                bcnt <= '0;
                if ({1'b0, pidx} < 9'(used_led)) begin
                  pend      <= 1'b1;
                  pend_addr <= pidx;
                end
                pidx <= pidx + 8'(pidx != 8'd255);
              end else bcnt <= bcnt + 5'd1;
            end
          end else if (hcnt >= CNT_MAX) begin
            err   <= 1'b1;
            state <= WAIT_RST;
            lcnt  <= '0;
            bcnt  <= '0;
            sr    <= '0;
            pidx  <= '0;
          end else hcnt <= hcnt + 16'(hcnt != 16'hFFFF);
        default: state <= WAIT_RST;
      endcase
    end
endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter clk_freq, default 50_000_000: sys_clk frequency in Hz; all timing thresholds derive from it.
REQ-002 Parameter used_led, default 1: number of pixels captured per frame (1..256).
REQ-003 sys_clk  input  1  the single clock; all logic is synchronous to it.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Di  input  1  WS2812 serial data line, asynchronous to sys_clk.
REQ-006 pixel_addr  output  8  index of the decoded pixel within the frame.
REQ-007 pixel_Red / pixel_Green / pixel_Blue  output  8 each  decoded colour bytes.
REQ-008 pixel_valid  output  1  one-cycle strobe; pixel_addr and the colour outputs are valid while it is high.
REQ-009 frame_done  output  1  one-cycle strobe on detection of a line reset that ends a frame.
REQ-010 err  output  1  one-cycle strobe on a protocol error.

Function
REQ-011 Di shall pass through a 2-flop synchronizer; edge detection uses the synchronized signal only.
REQ-012 Constants (integer division): cnt_min = clk_freq/10_000_000 (100 ns), cnt_thr = clk_freq/1_600_000 (625 ns), cnt_max = clk_freq/500_000 (2 us), cnt_rst = clk_freq/20_000 (50 us).
REQ-013 State machine: WAIT_RST, IDLE_LOW, HIGH, LOW.
REQ-014 WAIT_RST: Di low for cnt_rst consecutive cycles -> IDLE_LOW; any high restarts the count; no outputs fire.
REQ-015 IDLE_LOW / LOW on rising edge -> HIGH, clear high counter.
REQ-016 HIGH falling edge: high count < cnt_min -> glitch, ignored, return to previous low state with the low counter continuing; count >= cnt_thr -> bit 1; otherwise -> bit 0; then -> LOW.
REQ-017 HIGH with count reaching cnt_max -> err pulse, discard partial pixel, -> WAIT_RST.
REQ-018 Bits shift MSB first into a 24-bit register in G7..G0, R7..R0, B7..B0 order; a 5-bit counter counts 0..23.
REQ-019 24th bit accepted: if pixel index < used_led, pixel_valid pulses on the next cycle with Green = bits[23:16], Red = bits[15:8], Blue = bits[7:0]; bit counter clears and pixel index increments.
REQ-020 Pixels at index >= used_led are decoded but not emitted; the pixel index saturates at 255.
REQ-021 LOW count reaching cnt_rst: frame_done pulses; if the bit counter != 0, err also pulses in the same cycle and the partial pixel is discarded; pixel index clears; -> IDLE_LOW.
REQ-022 IDLE_LOW with no bits received produces no frame_done on further low time.
REQ-023 Latency from the falling edge of the 24th bit on Di to pixel_valid: 4 sys_clk cycles (2 sync + 1 decision + 1 register).
REQ-024 High and low counters are 16-bit and saturate; they never wrap.
REQ-025 pixel_addr and the colour outputs hold their last values between strobes.

Reset
REQ-026 rst_n low: all outputs 0, counters 0, shift register 0, synchronizer flops 0, state WAIT_RST.
REQ-027 Reset mid-frame discards all partial data; decoding resumes only after a full cnt_rst low period.

Structure
REQ-028 Timing constants (cnt_min, cnt_thr, cnt_max, cnt_rst) and the state encoding live in the shared package ws2812_pkg, which the transmitter uses as well.
REQ-029 Sub-module ws2812_sync: 2-flop synchronizer plus rise/fall detect.

Verification (clk_freq = 50 MHz: cnt_min = 5, cnt_thr = 31, cnt_max = 100, cnt_rst = 2500)
REQ-030 Send 3000 low cycles, then pixel 0x123456 (T1H = 42, T0H = 20, bit period 62), then 3000 low -> one pixel_valid with addr 0, G = 0x12, R = 0x34, B = 0x56; frame_done 2500 cycles after the last falling edge (+2 sync); err never fires.
REQ-031 used_led = 2, send 3 pixels 0x010203 / 0x040506 / 0x070809 -> pixel_valid twice (addr 0: G=01 R=02 B=03; addr 1: G=04 R=05 B=06); one frame_done.
REQ-032 High widths of 30 and 31 cycles -> decoded as 0 and 1 respectively; a 4-cycle high glitch inside a low gap -> ignored, pixel still decodes correctly.
REQ-033 Send 10 bits, then 3000 low -> no pixel_valid; frame_done and err pulse in the same cycle.
REQ-034 Drive valid pixels immediately after rst_n rises, with no preceding low gap -> no outputs until 2500 low cycles; a 120-cycle high pulse -> err, then WAIT_RST.
REQ-035 Assert rst_n at bit 12 of a pixel -> all outputs 0 immediately; the following frame, sent after a 2500-cycle low gap, decodes normally.
